// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: shares one UDP transmit core between two packetizers.
// ch0 carries AD/net samples and ch1 carries image data. Each channel's start
// pulse and length are latched as a pending request. One channel is granted
// per packet. The core handshake and data are steered to that channel, and an
// inter-packet gap and a stall watchdog are enforced.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no packet in flight; grant the next eligible pending channel
//   ST_START | one-cycle udp_tx_start_en to the core; grant already valid
//   ST_SEND  | core owns the granted channel; wait for done or watchdog
//   ST_GAP   | grant released; hold off GAP_CYC cycles before next packet
`timescale 1ns/1ps

module udp_tx_arbiter #(
    parameter int DATA_W      = 32,
    parameter int GAP_CYC     = 12,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              arb_en,
    input  logic [1:0]        arb_mode,
    input  logic              ch0_start_en,
    input  logic [15:0]       ch0_byte_num,
    input  logic [DATA_W-1:0] ch0_tx_data,
    output logic              ch0_tx_req,
    output logic              ch0_tx_done,
    input  logic              ch1_start_en,
    input  logic [15:0]       ch1_byte_num,
    input  logic [DATA_W-1:0] ch1_tx_data,
    output logic              ch1_tx_req,
    output logic              ch1_tx_done,
    output logic              udp_tx_start_en,
    output logic [15:0]       udp_tx_byte_num,
    output logic [DATA_W-1:0] udp_tx_data,
    input  logic              udp_tx_req,
    input  logic              udp_tx_done,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_overrun,
    output logic              err_zero_len
);

    // One shared down-counter serves both the watchdog and the gap timer.
    localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SEND  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_pend;
    logic [15:0]       r_len0;
    logic [15:0]       r_len1;
    logic              r_rr_last;
    logic [1:0]        r_grant;
    logic [15:0]       r_byte_num;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err_overrun;
    logic              r_err_zero_len;

    logic              w_req0_ok;
    logic              w_req1_ok;
    logic              w_set0;
    logic              w_set1;
    logic              w_elig0;
    logic              w_elig1;
    logic              w_pick0;
    logic              w_pick1;
    logic              w_take;
    logic              w_timeout;
    logic              w_in_send;
    logic              w_send_end;

    // Request qualification: zero-length starts are dropped, repeats while
    // pending are ignored so the first length is kept.
    assign w_req0_ok = ch0_start_en & (ch0_byte_num != 16'd0);
    assign w_req1_ok = ch1_start_en & (ch1_byte_num != 16'd0);
    assign w_set0    = w_req0_ok & ~r_pend[0];
    assign w_set1    = w_req1_ok & ~r_pend[1];

    // Mode 01 locks out ch1, mode 10 locks out ch0. With both eligible, mode 11
    // always picks ch0; mode 00 picks the channel that did not go last.
    assign w_elig0 = r_pend[0] & (arb_mode != 2'b10);
    assign w_elig1 = r_pend[1] & (arb_mode != 2'b01);
    assign w_pick0 = w_elig0 & (~w_elig1 | (arb_mode == 2'b11) | r_rr_last);
    assign w_pick1 = w_elig1 & ~w_pick0;

    // FSM next-state and per-cycle strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (arb_en && (w_pick0 || w_pick1)) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (udp_tx_done) begin
                    w_state_nxt = ST_GAP;
                end else if (r_cnt == '0) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_in_send  = (r_state == ST_SEND);
    assign w_send_end = w_in_send & (w_state_nxt == ST_GAP);

    // FSM state register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pending flags and latched lengths; a grant consumes the flag it picks.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_pend <= 2'b00;
            r_len0 <= 16'd0;
            r_len1 <= 16'd0;
        end else begin
            r_pend[0] <= (r_pend[0] & ~(w_take & w_pick0)) | w_set0;
            r_pend[1] <= (r_pend[1] & ~(w_take & w_pick1)) | w_set1;
            if (w_set0) begin
                r_len0 <= ch0_byte_num;
            end
            if (w_set1) begin
                r_len1 <= ch1_byte_num;
            end
        end
    end

    // Grant, outgoing length and round-robin history; grant drops with SEND.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_grant    <= 2'b00;
            r_byte_num <= 16'd0;
            r_rr_last  <= 1'b1;
        end else if (w_take) begin
            r_grant    <= {w_pick1, w_pick0};
            r_byte_num <= w_pick0 ? r_len0 : r_len1;
            r_rr_last  <= w_pick1;
        end else if (w_send_end) begin
            r_grant    <= 2'b00;
        end
    end

    // Watchdog / gap down-counter, reloaded on entry to SEND and to GAP.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_START) begin
            r_cnt <= CNT_W'(TIMEOUT_CYC - 1);
        end else if (w_send_end) begin
            r_cnt <= CNT_W'(GAP_CYC - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Request error pulses, registered so they stay clean through reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_err_overrun  <= 1'b0;
            r_err_zero_len <= 1'b0;
        end else begin
            r_err_overrun  <= (w_req0_ok & r_pend[0]) | (w_req1_ok & r_pend[1]);
            r_err_zero_len <= (ch0_start_en & (ch0_byte_num == 16'd0))
                            | (ch1_start_en & (ch1_byte_num == 16'd0));
        end
    end

    // Payload mux from the granted channel; zero when nobody owns the core.
    always_comb begin
        udp_tx_data = '0;
        if (r_grant[0]) begin
            udp_tx_data = ch0_tx_data;
        end else if (r_grant[1]) begin
            udp_tx_data = ch1_tx_data;
        end
    end

    assign ch0_tx_req      = udp_tx_req  & r_grant[0] & w_in_send;
    assign ch1_tx_req      = udp_tx_req  & r_grant[1] & w_in_send;
    assign ch0_tx_done     = udp_tx_done & r_grant[0] & w_in_send;
    assign ch1_tx_done     = udp_tx_done & r_grant[1] & w_in_send;
    assign udp_tx_start_en = (r_state == ST_START);
    assign udp_tx_byte_num = r_byte_num;
    assign grant           = r_grant;
    assign busy            = (r_state != ST_IDLE);
    assign err_timeout     = w_timeout;
    assign err_overrun     = r_err_overrun;
    assign err_zero_len    = r_err_zero_len;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Testbench for udp_tx_arbiter: directed stimulus, expected core starts are
// queued as they are requested and checked by a monitor on udp_tx_start_en.
`timescale 1ns/1ps

module tb_udp_tx_arbiter;

    localparam int DATA_W      = 32;
    localparam int GAP_CYC     = 4;
    localparam int TIMEOUT_CYC = 50;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              arb_en;
    logic [1:0]        arb_mode;
    logic              ch0_start_en;
    logic [15:0]       ch0_byte_num;
    logic [DATA_W-1:0] ch0_tx_data;
    logic              ch0_tx_req;
    logic              ch0_tx_done;
    logic              ch1_start_en;
    logic [15:0]       ch1_byte_num;
    logic [DATA_W-1:0] ch1_tx_data;
    logic              ch1_tx_req;
    logic              ch1_tx_done;
    logic              udp_tx_start_en;
    logic [15:0]       udp_tx_byte_num;
    logic [DATA_W-1:0] udp_tx_data;
    logic              udp_tx_req;
    logic              udp_tx_done;
    logic [1:0]        grant;
    logic              busy;
    logic              err_timeout;
    logic              err_overrun;
    logic              err_zero_len;

    udp_tx_arbiter #(
        .DATA_W      (DATA_W),
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .arb_en          (arb_en),
        .arb_mode        (arb_mode),
        .ch0_start_en    (ch0_start_en),
        .ch0_byte_num    (ch0_byte_num),
        .ch0_tx_data     (ch0_tx_data),
        .ch0_tx_req      (ch0_tx_req),
        .ch0_tx_done     (ch0_tx_done),
        .ch1_start_en    (ch1_start_en),
        .ch1_byte_num    (ch1_byte_num),
        .ch1_tx_data     (ch1_tx_data),
        .ch1_tx_req      (ch1_tx_req),
        .ch1_tx_done     (ch1_tx_done),
        .udp_tx_start_en (udp_tx_start_en),
        .udp_tx_byte_num (udp_tx_byte_num),
        .udp_tx_data     (udp_tx_data),
        .udp_tx_req      (udp_tx_req),
        .udp_tx_done     (udp_tx_done),
        .grant           (grant),
        .busy            (busy),
        .err_timeout     (err_timeout),
        .err_overrun     (err_overrun),
        .err_zero_len    (err_zero_len)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [1:0]  grant;
        logic [15:0] len;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every core start must match the next queued expectation.
    always @(negedge sys_clk) begin
        exp_t e;
        if (!sys_rst && udp_tx_start_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_start: got grant=%b len=%0d, expected no start", grant, udp_tx_byte_num);
            end else begin
                e = exp_q.pop_front();
                chk("start_grant", 32'(grant), 32'(e.grant));
                chk("start_len", 32'(udp_tx_byte_num), 32'(e.len));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_start(input string name);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1);
            if (udp_tx_start_en === 1'b1) found = 1;
        end
        chk(name, 32'(found), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1);
            if (busy === 1'b0) found = 1;
        end
        chk(name, 32'(found), 32'd1);
    endtask

    // Called in the START cycle; runs one SEND cycle with req/done, optionally
    // re-requesting ch0 during SEND.
    task automatic do_send(input int ch, input logic [31:0] data, input bit re0, input logic [15:0] relen);
        cyc(1);
        if (ch == 0) begin
            ch0_tx_data = data;
            ch1_tx_data = ~data;
        end else begin
            ch1_tx_data = data;
            ch0_tx_data = ~data;
        end
        if (re0) begin
            ch0_start_en = 1'b1;
            ch0_byte_num = relen;
            exp_q.push_back('{2'b01, relen});
        end
        udp_tx_req = 1'b1;
        #1;
        chk("send_req0", 32'(ch0_tx_req), (ch == 0) ? 32'd1 : 32'd0);
        chk("send_req1", 32'(ch1_tx_req), (ch == 1) ? 32'd1 : 32'd0);
        chk("send_data", udp_tx_data, data);
        udp_tx_done = 1'b1;
        #1;
        chk("send_done0", 32'(ch0_tx_done), (ch == 0) ? 32'd1 : 32'd0);
        chk("send_done1", 32'(ch1_tx_done), (ch == 1) ? 32'd1 : 32'd0);
        cyc(1);
        ch0_start_en = 1'b0;
        udp_tx_req   = 1'b0;
        udp_tx_done  = 1'b0;
        chk("gap_grant", 32'(grant), 32'd0);
        chk("gap_busy", 32'(busy), 32'd1);
    endtask

    initial begin
        sys_rst      = 1'b1;
        arb_en       = 1'b1;
        arb_mode     = 2'b00;
        ch0_start_en = 1'b0;
        ch0_byte_num = 16'd0;
        ch0_tx_data  = '0;
        ch1_start_en = 1'b0;
        ch1_byte_num = 16'd0;
        ch1_tx_data  = '0;
        udp_tx_req   = 1'b0;
        udp_tx_done  = 1'b0;

        // Reset state
        cyc(3);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(udp_tx_start_en), 32'd0);
        chk("rst_len", 32'(udp_tx_byte_num), 32'd0);
        chk("rst_errs", 32'({err_timeout, err_overrun, err_zero_len}), 32'd0);
        sys_rst = 1'b0;
        cyc(1);

        // Single request: start appears two cycles after the request
        ch0_start_en = 1'b1;
        ch0_byte_num = 16'd100;
        exp_q.push_back('{2'b01, 16'd100});
        cyc(1);
        ch0_start_en = 1'b0;
        chk("single_start_lat1", 32'(udp_tx_start_en), 32'd0);
        cyc(1);
        chk("single_start_lat2", 32'(udp_tx_start_en), 32'd1);
        chk("single_grant", 32'(grant), 32'd1);
        do_send(0, 32'hA5A5_0001, 1'b0, 16'd0);
        cyc(GAP_CYC - 1);
        chk("single_gap_busy", 32'(busy), 32'd1);
        cyc(1);
        chk("single_idle", 32'(busy), 32'd0);

        // Round-robin from reset: ch0 first, then ch1
        sys_rst = 1'b1;
        cyc(1);
        sys_rst = 1'b0;
        ch0_start_en = 1'b1;
        ch0_byte_num = 16'd64;
        ch1_start_en = 1'b1;
        ch1_byte_num = 16'd1024;
        exp_q.push_back('{2'b01, 16'd64});
        exp_q.push_back('{2'b10, 16'd1024});
        cyc(1);
        ch0_start_en = 1'b0;
        ch1_start_en = 1'b0;
        wait_start("rr_first");
        do_send(0, 32'h1111_2222, 1'b0, 16'd0);
        wait_start("rr_second");
        chk("rr_second_grant", 32'(grant), 32'd2);
        do_send(1, 32'h3333_4444, 1'b0, 16'd0);
        wait_idle("rr_idle");

        // Mode 10 hides ch0; switching to mode 11 grants it
        arb_mode = 2'b10;
        ch0_start_en = 1'b1;
        ch0_byte_num = 16'd200;
        cyc(1);
        ch0_start_en = 1'b0;
        cyc(8);
        chk("mode10_nogrant", 32'(grant), 32'd0);
        chk("mode10_idle", 32'(busy), 32'd0);
        exp_q.push_back('{2'b01, 16'd200});
        arb_mode = 2'b11;
        wait_start("mode11_start");
        do_send(0, 32'h5555_6666, 1'b0, 16'd0);
        wait_idle("mode11_idle");

        // Mode 11 starvation: ch0 re-requests and wins over waiting ch1
        ch0_start_en = 1'b1;
        ch0_byte_num = 16'd400;
        ch1_start_en = 1'b1;
        ch1_byte_num = 16'd300;
        exp_q.push_back('{2'b01, 16'd400});
        cyc(1);
        ch0_start_en = 1'b0;
        ch1_start_en = 1'b0;
        wait_start("starve_a");
        do_send(0, 32'h7777_0001, 1'b1, 16'd500);
        wait_start("starve_b");
        do_send(0, 32'h7777_0002, 1'b0, 16'd0);
        exp_q.push_back('{2'b10, 16'd300});
        wait_start("starve_ch1");
        do_send(1, 32'h7777_0003, 1'b0, 16'd0);
        wait_idle("starve_idle");
        arb_mode = 2'b00;

        // Errors: overrun keeps the first length; zero length is dropped
        arb_en = 1'b0;
        ch1_start_en = 1'b1;
        ch1_byte_num = 16'd80;
        cyc(1);
        ch1_byte_num = 16'd90;
        cyc(1);
        ch1_start_en = 1'b0;
        chk("overrun_pulse", 32'(err_overrun), 32'd1);
        cyc(1);
        chk("overrun_clear", 32'(err_overrun), 32'd0);
        ch0_start_en = 1'b1;
        ch0_byte_num = 16'd0;
        cyc(1);
        ch0_start_en = 1'b0;
        chk("zero_len_pulse", 32'(err_zero_len), 32'd1);
        cyc(1);
        chk("zero_len_clear", 32'(err_zero_len), 32'd0);
        chk("arb_dis_idle", 32'(busy), 32'd0);
        exp_q.push_back('{2'b10, 16'd80});
        arb_en = 1'b1;
        wait_start("overrun_start");
        do_send(1, 32'h9999_0001, 1'b0, 16'd0);
        wait_idle("err_idle");

        // Watchdog: no done, abort in the 50th SEND cycle
        ch0_start_en = 1'b1;
        ch0_byte_num = 16'd128;
        exp_q.push_back('{2'b01, 16'd128});
        cyc(1);
        ch0_start_en = 1'b0;
        wait_start("wd_start");
        cyc(1);
        chk("wd_cycle1", 32'(err_timeout), 32'd0);
        cyc(TIMEOUT_CYC - 2);
        chk("wd_cycle49", 32'(err_timeout), 32'd0);
        chk("wd_grant49", 32'(grant), 32'd1);
        cyc(1);
        chk("wd_cycle50", 32'(err_timeout), 32'd1);
        cyc(1);
        chk("wd_after", 32'(err_timeout), 32'd0);
        chk("wd_gap_grant", 32'(grant), 32'd0);
        udp_tx_done = 1'b1;
        udp_tx_req  = 1'b1;
        #1;
        chk("wd_late_done", 32'({ch1_tx_done, ch0_tx_done}), 32'd0);
        chk("wd_late_req", 32'({ch1_tx_req, ch0_tx_req}), 32'd0);
        cyc(1);
        udp_tx_done = 1'b0;
        udp_tx_req  = 1'b0;
        wait_idle("wd_idle");

        // Reset mid-SEND drops state and pending requests
        ch1_start_en = 1'b1;
        ch1_byte_num = 16'd256;
        exp_q.push_back('{2'b10, 16'd256});
        cyc(1);
        ch1_start_en = 1'b0;
        wait_start("rst_mid_start");
        cyc(1);
        ch0_start_en = 1'b1;
        ch0_byte_num = 16'd99;
        cyc(1);
        ch0_start_en = 1'b0;
        sys_rst    = 1'b1;
        udp_tx_req = 1'b1;
        cyc(1);
        chk("rstm_grant", 32'(grant), 32'd0);
        chk("rstm_busy", 32'(busy), 32'd0);
        chk("rstm_len", 32'(udp_tx_byte_num), 32'd0);
        chk("rstm_req", 32'({ch1_tx_req, ch0_tx_req}), 32'd0);
        sys_rst    = 1'b0;
        udp_tx_req = 1'b0;
        cyc(4);
        chk("rstm_pend_lost", 32'(busy), 32'd0);
        ch1_start_en = 1'b1;
        ch1_byte_num = 16'd77;
        exp_q.push_back('{2'b10, 16'd77});
        cyc(1);
        ch1_start_en = 1'b0;
        wait_start("rstm_new_start");
        do_send(1, 32'hBEEF_0077, 1'b0, 16'd0);
        wait_idle("final_idle");

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
